// File: rtl/tlb_refill_arbiter.sv
// tlb_refill_arbiter: round-robin refill controller sharing one page-table walker among N TLB ports.
module tlb_refill_arbiter #(
    parameter int N_PORTS = 2,
    parameter int VPN_W   = 27,
    parameter int TIMEOUT = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_PORTS-1:0]       req_valid,
    input  logic [N_PORTS-1:0]       req_miss,
    input  logic [N_PORTS*VPN_W-1:0] req_vpn,
    input  logic [N_PORTS-1:0]       req_instruction,
    input  logic [N_PORTS-1:0]       req_store,
    output logic [N_PORTS-1:0]       req_ready,
    output logic [N_PORTS-1:0]       resp_miss,
    input  logic                     sfence_valid,
    input  logic                     ptw_status_pum,
    input  logic                     ptw_status_mxr,
    input  logic [1:0]               ptw_status_prv,
    output logic                     ptw_req_valid,
    input  logic                     ptw_req_ready,
    output logic [VPN_W-1:0]         ptw_req_bits_addr,
    output logic                     ptw_req_bits_fetch,
    output logic                     ptw_req_bits_store,
    output logic                     ptw_req_bits_pum,
    output logic                     ptw_req_bits_mxr,
    output logic [1:0]               ptw_req_bits_prv,
    input  logic                     ptw_resp_valid,
    output logic [N_PORTS-1:0]       refill_valid,
    output logic [VPN_W-1:0]         refill_vpn,
    output logic                     err_timeout
);
    localparam int SRC_W = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQUEST, WAIT, WAIT_INVALIDATE} state_t;

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   rr_ptr, src, winner, j;
    logic [VPN_W-1:0]   vpn;
    logic               instruction, store;
    logic [CNT_W-1:0]   cnt;
    logic [N_PORTS-1:0] cand;
    logic               grant, waiting, timeout_hit;

    assign cand        = req_valid & req_miss;
    assign grant       = state == IDLE && |cand && !sfence_valid;
    assign waiting     = state == WAIT || state == WAIT_INVALIDATE;
    assign timeout_hit = TIMEOUT > 0 && waiting && cnt == CNT_W'(TIMEOUT - 1) && !ptw_resp_valid;

    // Scan from the far end so the candidate closest to rr_ptr is the last to assign.
    always_comb begin
        winner = rr_ptr;
        j = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            j = SRC_W'((int'(rr_ptr) + k) % N_PORTS);
            if (cand[j]) winner = j;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:            state_nxt = grant ? REQUEST : IDLE;
            REQUEST:         state_nxt = ptw_req_ready ? (sfence_valid ? WAIT_INVALIDATE : WAIT)
                                                       : (sfence_valid ? IDLE : REQUEST);
            WAIT:            state_nxt = (ptw_resp_valid || timeout_hit) ? IDLE
                                       : (sfence_valid ? WAIT_INVALIDATE : WAIT);
            WAIT_INVALIDATE: state_nxt = (ptw_resp_valid || timeout_hit) ? IDLE : WAIT_INVALIDATE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            src         <= '0;
            vpn         <= '0;
            instruction <= 1'b0;
            store       <= 1'b0;
            cnt         <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                src         <= winner;
                vpn         <= req_vpn[winner*VPN_W +: VPN_W];
                instruction <= req_instruction[winner];
                store       <= req_store[winner];
                rr_ptr      <= SRC_W'((int'(winner) + 1) % N_PORTS);
            end
            if (state == IDLE)
                cnt <= '0;
            else if (waiting && cnt != '1)
                cnt <= cnt + CNT_W'(1);
        end
    end

    assign req_ready          = {N_PORTS{state == IDLE}};
    assign resp_miss          = req_valid & (req_miss | {N_PORTS{ptw_resp_valid || state != IDLE}});
    assign ptw_req_valid      = state == REQUEST;
    assign ptw_req_bits_addr  = vpn;
    assign ptw_req_bits_fetch = instruction;
    assign ptw_req_bits_store = store;
    assign ptw_req_bits_pum   = ptw_status_pum;
    assign ptw_req_bits_mxr   = ptw_status_mxr;
    assign ptw_req_bits_prv   = ptw_status_prv;
    assign refill_valid       = (state == WAIT && ptw_resp_valid) ? N_PORTS'(1) << src : '0;
    assign refill_vpn         = vpn;
    assign err_timeout        = timeout_hit;
endmodule

// File: tb/tb_tlb_refill_arbiter.sv
// tb_tlb_refill_arbiter: directed bench with a refill scoreboard for the TLB refill arbiter.
module tb_tlb_refill_arbiter;
    localparam int N = 2;
    localparam int W = 27;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid, req_miss, req_instruction, req_store;
    logic [N*W-1:0] req_vpn;
    logic [N-1:0] req_ready, resp_miss, refill_valid;
    logic         sfence_valid, ptw_status_pum, ptw_status_mxr;
    logic [1:0]   ptw_status_prv, ptw_req_bits_prv;
    logic         ptw_req_valid, ptw_req_ready, ptw_req_bits_fetch, ptw_req_bits_store;
    logic         ptw_req_bits_pum, ptw_req_bits_mxr, ptw_resp_valid, err_timeout;
    logic [W-1:0] ptw_req_bits_addr, refill_vpn;

    typedef struct {
        int           port;
        logic [W-1:0] vpn;
    } exp_t;
    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    tlb_refill_arbiter #(.N_PORTS(N), .VPN_W(W), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_miss(req_miss), .req_vpn(req_vpn),
        .req_instruction(req_instruction), .req_store(req_store),
        .req_ready(req_ready), .resp_miss(resp_miss), .sfence_valid(sfence_valid),
        .ptw_status_pum(ptw_status_pum), .ptw_status_mxr(ptw_status_mxr),
        .ptw_status_prv(ptw_status_prv), .ptw_req_valid(ptw_req_valid),
        .ptw_req_ready(ptw_req_ready), .ptw_req_bits_addr(ptw_req_bits_addr),
        .ptw_req_bits_fetch(ptw_req_bits_fetch), .ptw_req_bits_store(ptw_req_bits_store),
        .ptw_req_bits_pum(ptw_req_bits_pum), .ptw_req_bits_mxr(ptw_req_bits_mxr),
        .ptw_req_bits_prv(ptw_req_bits_prv), .ptw_resp_valid(ptw_resp_valid),
        .refill_valid(refill_valid), .refill_vpn(refill_vpn), .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic miss(input logic [N-1:0] ports, input logic [W-1:0] v0, input logic [W-1:0] v1);
        req_valid = ports;
        req_miss  = ports;
        req_vpn   = {v1, v0};
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_miss  = '0;
        req_instruction = '0;
        req_store = '0;
    endtask

    task automatic check_refill(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_refill_valid"}, 64'(refill_valid), 64'(N'(1) << e.port));
            chk({tag, "_refill_vpn"}, 64'(refill_vpn), 64'(e.vpn));
        end
    endtask

    initial begin
        reset = 1'b1;
        req_vpn = '0;
        idle_inputs();
        sfence_valid = 0; ptw_req_ready = 0; ptw_resp_valid = 0;
        ptw_status_pum = 1; ptw_status_mxr = 0; ptw_status_prv = 2'b11;
        tick(); tick();
        reset = 1'b0;
        settle();
        chk("rst_ready", 64'(req_ready), 64'h3);
        chk("rst_ptw_valid", 64'(ptw_req_valid), 64'h0);
        chk("rst_refill", 64'(refill_valid), 64'h0);
        chk("rst_addr", 64'(ptw_req_bits_addr), 64'h0);
        chk("rst_err", 64'(err_timeout), 64'h0);

        // Single miss on port 1 with a delayed walker accept.
        tick();
        miss(2'b10, 27'h0, 27'h123);
        req_instruction = 2'b10;
        settle();
        chk("t1_resp_miss", 64'(resp_miss), 64'h2);
        sb.push_back('{1, 27'h123});
        tick();
        idle_inputs();
        settle();
        chk("t1_req_valid", 64'(ptw_req_valid), 64'h1);
        chk("t1_addr", 64'(ptw_req_bits_addr), 64'h123);
        chk("t1_fetch", 64'(ptw_req_bits_fetch), 64'h1);
        chk("t1_ready_low", 64'(req_ready), 64'h0);
        chk("t1_status", 64'({ptw_req_bits_pum, ptw_req_bits_mxr, ptw_req_bits_prv}), 64'hB);
        tick();
        chk("t1_req_hold", 64'(ptw_req_valid), 64'h1);
        ptw_req_ready = 1;
        tick();
        ptw_req_ready = 0;
        settle();
        chk("t1_wait", 64'(ptw_req_valid), 64'h0);
        tick();
        ptw_resp_valid = 1;
        settle();
        check_refill("t1");
        tick();
        ptw_resp_valid = 0;
        settle();
        chk("t1_idle", 64'(req_ready), 64'h3);

        // Both ports miss every idle cycle; grants alternate starting at port 0.
        for (int g = 0; g < 4; g++) begin
            miss(2'b11, 27'h400 + 27'(g), 27'h500 + 27'(g));
            settle();
            chk("t2_resp_miss", 64'(resp_miss), 64'h3);
            sb.push_back('{g % 2, (g % 2 == 0) ? 27'h400 + 27'(g) : 27'h500 + 27'(g)});
            tick();
            idle_inputs();
            ptw_req_ready = 1;
            settle();
            chk("t2_addr", 64'(ptw_req_bits_addr), 64'((g % 2 == 0) ? 27'h400 + 27'(g) : 27'h500 + 27'(g)));
            tick();
            ptw_req_ready = 0;
            ptw_resp_valid = 1;
            settle();
            check_refill("t2");
            tick();
            ptw_resp_valid = 0;
        end

        // Sfence withdraws an unaccepted request, then invalidates an in-flight walk.
        miss(2'b01, 27'h55, 27'h0);
        tick();
        idle_inputs();
        sfence_valid = 1;
        tick();
        sfence_valid = 0;
        settle();
        chk("t3_withdrawn", 64'(ptw_req_valid), 64'h0);
        chk("t3_idle", 64'(req_ready), 64'h3);
        miss(2'b01, 27'h66, 27'h0);
        tick();
        idle_inputs();
        ptw_req_ready = 1;
        tick();
        ptw_req_ready = 0;
        sfence_valid = 1;
        tick();
        sfence_valid = 0;
        ptw_resp_valid = 1;
        settle();
        chk("t3_inv_refill", 64'(refill_valid), 64'h0);
        chk("t3_inv_busy", 64'(req_ready), 64'h0);
        tick();
        ptw_resp_valid = 0;
        settle();
        chk("t3_inv_idle", 64'(req_ready), 64'h3);

        // Walker never answers: abort on the 8th wait cycle.
        miss(2'b10, 27'h0, 27'h77);
        tick();
        idle_inputs();
        ptw_req_ready = 1;
        tick();
        ptw_req_ready = 0;
        for (int c = 1; c <= 8; c++) begin
            settle();
            chk("t4_err", 64'(err_timeout), 64'(c == 8));
            tick();
        end
        settle();
        chk("t4_idle", 64'(req_ready), 64'h3);
        chk("t4_err_clear", 64'(err_timeout), 64'h0);
        ptw_resp_valid = 1;
        settle();
        chk("t4_stale", 64'(refill_valid), 64'h0);
        tick();
        ptw_resp_valid = 0;

        // Reset mid-walk.
        miss(2'b01, 27'h88, 27'h0);
        tick();
        idle_inputs();
        ptw_req_ready = 1;
        tick();
        ptw_req_ready = 0;
        reset = 1;
        tick();
        reset = 0;
        settle();
        chk("t5_ready", 64'(req_ready), 64'h3);
        chk("t5_addr", 64'(ptw_req_bits_addr), 64'h0);
        chk("t5_refill_vpn", 64'(refill_vpn), 64'h0);
        ptw_resp_valid = 1;
        settle();
        chk("t5_stale", 64'(refill_valid), 64'h0);
        tick();
        ptw_resp_valid = 0;
        miss(2'b11, 27'h9A, 27'h9B);
        tick();
        idle_inputs();
        settle();
        chk("t5_rr_reset", 64'(ptw_req_bits_addr), 64'h9A);
        sfence_valid = 1;
        tick();
        sfence_valid = 0;

        // Response and sfence together in wait: the refill still happens.
        miss(2'b10, 27'h0, 27'hAB);
        req_store = 2'b10;
        sb.push_back('{1, 27'hAB});
        tick();
        idle_inputs();
        settle();
        chk("t6_store", 64'(ptw_req_bits_store), 64'h1);
        ptw_req_ready = 1;
        tick();
        ptw_req_ready = 0;
        ptw_resp_valid = 1;
        sfence_valid = 1;
        settle();
        check_refill("t6");
        tick();
        ptw_resp_valid = 0;
        sfence_valid = 0;
        settle();
        chk("t6_idle", 64'(req_ready), 64'h3);
        chk("sb_drained", 64'(sb.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
